// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder slice: state encoding, default widths,
// wait-counter width and request op type.
package mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/memory_responder_if.sv
// MAR/MDR memory bus between the datapath/sequencer (master) and the responder (slave).
interface memory_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] MAR_addr;
    logic [DATA_W-1:0] MDR_wdata;
    logic              Read;
    logic              Write;
    logic [DATA_W-1:0] Mdatain;
    logic              MemReady;
    logic              MemBusy;
    logic              RdWrErr;

    modport master (
        output MAR_addr, MDR_wdata, Read, Write,
        input  Mdatain, MemReady, MemBusy, RdWrErr
    );

    modport slave (
        input  MAR_addr, MDR_wdata, Read, Write,
        output Mdatain, MemReady, MemBusy, RdWrErr
    );

endinterface

// File: rtl/memory_responder_array.sv
// Single-port word RAM with synchronous write and registered synchronous read.
// The read register is cleared by rst; the storage itself is never cleared.
module mem_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Wait-state memory responder for the MAR/MDR interface.
// Define MEM_WAIT_EN to honour WAIT_STATES; otherwise every access completes on its first ACCESS edge.
module memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic                 Clock,
    input  logic                 clr,
    memory_responder_if.slave    bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("memory_responder: WAIT_STATES out of range 0..15");
    end

    state_t            state_q, state_d;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_ready_q;
    logic              mem_busy_q;
    logic              rdwr_err_q;
    logic              accept;
    logic              conflict;
    logic              access;
    logic              wait_done;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_WAIT_EN
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clock) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= WAIT_LOAD;
        end else if (state_q == ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign wait_done = (cnt_q == '0);
`else
    assign wait_done = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        conflict = 1'b0;
        access   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Read && bus.Write) begin
                    conflict = 1'b1;
                end else if (bus.Read || bus.Write) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_done) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with clr keeps an in-flight write from landing on the reset edge.
    assign ram_we = access && !clr && (op_q == OP_WRITE);
    assign ram_re = access && !clr && (op_q == OP_READ);

    always_ff @(posedge Clock) begin
        if (clr) begin
            state_q     <= IDLE;
            mem_ready_q <= 1'b0;
            mem_busy_q  <= 1'b0;
            rdwr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= access;
            mem_busy_q  <= (state_d != IDLE);
            rdwr_err_q  <= conflict;
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            addr_q  <= bus.MAR_addr;
            wdata_q <= bus.MDR_wdata;
            op_q    <= bus.Write ? OP_WRITE : OP_READ;
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (Clock),
        .rst  (clr),
        .we   (ram_we),
        .re   (ram_re),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign bus.Mdatain  = ram_rdata;
    assign bus.MemReady = mem_ready_q;
    assign bus.MemBusy  = mem_busy_q;
    assign bus.RdWrErr  = rdwr_err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: driver pushes expected completions, monitor checks them.
module tb_memory_responder;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
`ifdef MEM_WAIT_EN
    localparam int WS  = 2;
    localparam int EFF = 2;
`else
    localparam int WS  = 5;
    localparam int EFF = 0;
`endif

    typedef struct {
        int                acc;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic Clock = 1'b0;
    logic clr   = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [16];
    logic [DATA_W-1:0] last_rd;

    memory_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memory_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WAIT_STATES(WS)
    ) dut (
        .Clock(Clock),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every MemReady pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (!clr && bus.MemReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ready_cycle", 64'(cyc - e.acc), 64'(EFF + 2));
                    check("mdatain", bus.Mdatain, e.data);
                    check("busy_at_ready", bus.MemBusy, 1);
                end
            end
        end
    end

    task automatic wait_ready();
        bit seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge Clock);
            if (bus.MemReady) begin
                seen = 1;
                bus.Read  = 1'b0;
                bus.Write = 1'b0;
            end else begin
                // Operands and request levels are don't-care while in flight.
                bus.MAR_addr  = ADDR_W'($urandom);
                bus.MDR_wdata = $urandom;
                bus.Read      = 1'($urandom);
                bus.Write     = 1'($urandom);
            end
        end
        if (!seen) check("ready_timeout", 0, 1);
    endtask

    task automatic issue(input bit is_wr, input int a, input logic [DATA_W-1:0] d);
        exp_t e;
        @(negedge Clock);
        bus.MAR_addr  = ADDR_W'(a);
        bus.MDR_wdata = d;
        bus.Read      = !is_wr;
        bus.Write     = is_wr;
        e.acc = cyc;
        if (is_wr) begin
            model[a] = d;
            e.data   = last_rd;
        end else begin
            last_rd = model[a];
            e.data  = last_rd;
        end
        sb.push_back(e);
    endtask

    task automatic do_req(input bit is_wr, input int a, input logic [DATA_W-1:0] d);
        issue(is_wr, a, d);
        wait_ready();
    endtask

    task automatic do_conflict(input int a);
        @(negedge Clock);
        bus.MAR_addr  = ADDR_W'(a);
        bus.MDR_wdata = $urandom;
        bus.Read      = 1'b1;
        bus.Write     = 1'b1;
        @(negedge Clock);
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        check("rdwrerr_pulse", bus.RdWrErr, 1);
        check("conflict_busy", bus.MemBusy, 0);
        @(negedge Clock);
        check("rdwrerr_clear", bus.RdWrErr, 0);
        check("conflict_busy2", bus.MemBusy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MAR_addr  = '0;
        bus.MDR_wdata = '0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        last_rd       = '0;
        repeat (2) @(negedge Clock);
        check("reset_mdatain", bus.Mdatain, 0);
        check("reset_ready", bus.MemReady, 0);
        check("reset_busy", bus.MemBusy, 0);
        check("reset_err", bus.RdWrErr, 0);
        clr = 1'b0;

        for (int a = 0; a < 16; a++) do_req(1, a, $urandom);

        do_req(1, 0, 32'h4A92_0000);
        do_req(0, 0, 'x);
        do_req(1, 2, 32'h0000_0022);
        do_req(1, 4, 32'h0000_0024);
        issue(0, 2, 'x);
        @(negedge Clock);
        bus.MAR_addr = ADDR_W'(4);
        bus.Read     = 1'b0;
        wait_ready();

        do_conflict(2);
        do_req(0, 2, 'x);

        // Abandoned write: clr during ACCESS must leave address 5 untouched.
        do_req(1, 5, 32'h0000_0000);
        do_req(0, 3, 'x);
        issue(1, 5, 32'h0000_0026);
        model[5] = 32'h0000_0000;
        @(negedge Clock);
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        clr       = 1'b1;
        @(negedge Clock);
        clr = 1'b0;
        void'(sb.pop_back());
        last_rd = '0;
        check("midreset_mdatain", bus.Mdatain, 0);
        check("midreset_ready", bus.MemReady, 0);
        check("midreset_busy", bus.MemBusy, 0);
        do_req(0, 5, 'x);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            if ($urandom_range(0, 7) == 0) do_conflict($urandom_range(0, 15));
            else do_req(1'($urandom), $urandom_range(0, 15), $urandom);
        end

        repeat (4) @(negedge Clock);
        check("scoreboard_empty", 64'(sb.size()), 0);
        check("idle_busy", bus.MemBusy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
